periph_bus_bridge: RTL and testbench
====================================

// Module: periph_bus_bridge
// PURPOSE
// Parametrised memory-mapped peripheral interconnect between the core data port and N peripheral slots.
// Successor to the fixed UART/GPIO/timer decode at SoC level: N equal-size slots, registered request
// latch, multi-cycle slave handshake, per-access timeout and sticky bus-error capture.
// Sits between rv32i_core data interface and peripheral register blocks; memory (flash/PSRAM) traffic is not routed here.
// PARAMETERS
// N_SLAVES        4             number of peripheral slots (1..16)
// BASE_ADDR       32'h40000000  base of slot 0; must be aligned to 2^SLOT_SHIFT
// SLOT_SHIFT      12            log2 slot size in bytes (4 KiB slots)
// TIMEOUT_CYCLES  255           ACCESS cycles without s_ready before abort (1..2^TIMEOUT_W-1)
// TIMEOUT_W       8             timeout counter width
// PORTS
// clk         in   1           system clock
// rst_n       in   1           asynchronous active-low reset
// mem_addr    in   32          core data address
// mem_wdata   in   32          core write data
// mem_flag    in   3           core access size/sign flag (funct3), forwarded unchanged
// mem_we      in   1           core write request (level, held until mem_ready)
// mem_re      in   1           core read request (level, held until mem_ready)
// mem_rdata   out  32          read data, valid while mem_ready=1
// mem_ready   out  1           one-cycle completion pulse
// s_sel       out  N_SLAVES    one-hot slot select, held for whole ACCESS
// s_addr      out  SLOT_SHIFT  latched offset within slot
// s_wdata     out  32          latched write data
// s_flag      out  3           latched mem_flag
// s_we        out  1           write strobe, held during ACCESS
// s_re        out  1           read strobe, held during ACCESS
// s_rdata     in   32*N_SLAVES slot k read data at bits [32k+31:32k]
// s_ready     in   N_SLAVES    slot k completion; only bit of selected slot is observed
// bus_err     out  1           sticky error flag
// err_cause   out  2           01 unmapped, 10 timeout; held with bus_err
// err_addr    out  32          address of first faulting access
// err_clr     in   1           synchronous clear of bus_err/err_cause/err_addr
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE; all outputs 0 (mem_rdata, mem_ready, s_*, bus_err, err_cause, err_addr, counter).
//   Reset mid-ACCESS aborts immediately; no mem_ready is produced for the aborted access.
// - Decode: off = mem_addr - BASE_ADDR; hit = (mem_addr >= BASE_ADDR) && (off>>SLOT_SHIFT) < N_SLAVES; slot = off>>SLOT_SHIFT.
// - FSM IDLE: if (mem_we|mem_re): latch addr offset, wdata, flag, we, re=re&~we (write wins if both);
//   hit -> ACCESS (s_sel[slot]=1, counter=0); miss -> RESP with error UNMAPPED.
// - ACCESS: s_sel/s_we/s_re driven from latches. s_ready[slot]=1 -> capture s_rdata[slot] (reads; writes capture 0), go RESP.
//   Else counter++; counter==TIMEOUT_CYCLES-1 without ready -> RESP with error TIMEOUT. s_sel/s_we/s_re drop on exit.
// - RESP: mem_ready=1 for exactly one cycle; mem_rdata = captured data (0 on any error); next IDLE.
//   Core contract: request deasserted in the cycle after mem_ready; IDLE never re-issues in RESP cycle.
// - Latency: hit with immediate s_ready -> mem_ready 2 cycles after request seen; miss -> 1 cycle.
// - Error capture: on error, if bus_err==0 set bus_err, err_cause, err_addr=full address; later errors keep first record.
//   err_clr in same cycle as new error: new error wins (recorded). mem_ready still pulses on error (no hang).
// - s_ready from non-selected slots and s_ready outside ACCESS ignored. s_sel is never multi-hot.
// - Last slot boundary: BASE_ADDR + N_SLAVES*2^SLOT_SHIFT - 1 is hit; +1 is unmapped. No 32-bit wrap: addresses below BASE_ADDR miss.
// TESTING
// - Read slot 2 (0x40002004), s_ready[2] in first ACCESS cycle, s_rdata slot2=0x12345678 -> s_sel=0100, s_addr=0x004, mem_ready 2 cycles later, mem_rdata=0x12345678.
// - Write slot 0 (0x40000010, wdata 0xA5A5A5A5) with s_ready after 5 cycles -> s_we held 6 ACCESS cycles, one mem_ready, bus_err=0.
// - Read 0x40004000 (N_SLAVES=4) -> mem_ready after 1 cycle, mem_rdata=0, bus_err=1, err_cause=01, err_addr=0x40004000.
// - Read slot 1, s_ready never asserted -> mem_ready exactly TIMEOUT_CYCLES+1 cycles after request, err_cause=10; second fault keeps first err_addr; err_clr -> all error outputs 0.
// - Spurious s_ready[3] during slot 1 access, and mem_we&mem_re together -> ignored/treated as write; rst_n low mid-ACCESS -> all outputs 0, no mem_ready.

Source files
------------

// File: rtl/periph_bus_bridge_if.sv
// Core-side request/response and peripheral-slot signals of the bridge.
// master: core/peripheral side; slave: the bridge itself.
interface periph_bus_bridge_if #(
   parameter int unsigned N_SLAVES   = 4,
   parameter int unsigned SLOT_SHIFT = 12
);
   logic [31:0]            mem_addr;
   logic [31:0]            mem_wdata;
   logic [2:0]             mem_flag;
   logic                   mem_we;
   logic                   mem_re;
   logic [31:0]            mem_rdata;
   logic                   mem_ready;
   logic [N_SLAVES-1:0]    s_sel;
   logic [SLOT_SHIFT-1:0]  s_addr;
   logic [31:0]            s_wdata;
   logic [2:0]             s_flag;
   logic                   s_we;
   logic                   s_re;
   logic [32*N_SLAVES-1:0] s_rdata;
   logic [N_SLAVES-1:0]    s_ready;
   logic                   bus_err;
   logic [1:0]             err_cause;
   logic [31:0]            err_addr;
   logic                   err_clr;

   modport slave (
      input  mem_addr, mem_wdata, mem_flag, mem_we, mem_re,
      input  s_rdata, s_ready, err_clr,
      output mem_rdata, mem_ready,
      output s_sel, s_addr, s_wdata, s_flag, s_we, s_re,
      output bus_err, err_cause, err_addr
   );

   modport master (
      output mem_addr, mem_wdata, mem_flag, mem_we, mem_re,
      output s_rdata, s_ready, err_clr,
      input  mem_rdata, mem_ready,
      input  s_sel, s_addr, s_wdata, s_flag, s_we, s_re,
      input  bus_err, err_cause, err_addr
   );
endinterface

// File: rtl/periph_bus_bridge.sv
// Core data port to N equal-size peripheral slots: latched request,
// multi-cycle slot handshake, access timeout and sticky error capture.
module periph_bus_bridge #(
   parameter int unsigned N_SLAVES       = 4,
   parameter logic [31:0] BASE_ADDR      = 32'h4000_0000,
   parameter int unsigned SLOT_SHIFT     = 12,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned TIMEOUT_W      = 8
) (
   input logic                clk,
   input logic                rst_n,
   periph_bus_bridge_if.slave bus
);
   localparam int unsigned SW =
      (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
   localparam logic [1:0] CAUSE_UNMAPPED = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
   localparam logic [TIMEOUT_W-1:0] CNT_LAST =
      TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   state_t state;
   state_t state_nx;

   logic [31:0]          off;
   logic [31:0]          slot_wide;
   logic                 hit;
   logic [SW-1:0]        slot;
   logic                 req;

   logic [31:0]          addr_q;
   logic [31:0]          wdata_q;
   logic [31:0]          rdata_q;
   logic [2:0]           flag_q;
   logic                 we_q;
   logic                 re_q;
   logic [SW-1:0]        slot_q;
   logic [TIMEOUT_W-1:0] cnt;

   logic                 sel_ready;
   logic [31:0]          sel_rdata;
   logic [N_SLAVES-1:0]  sel_dec;

   logic                 latch_req;
   logic                 capture;
   logic                 err_set;
   logic [1:0]           err_kind;
   logic [31:0]          err_at;

   logic                 err_q;
   logic [1:0]           cause_q;
   logic [31:0]          eaddr_q;

   // Addresses below the base must miss, so the subtraction never wraps into a hit.
   assign off       = bus.mem_addr - BASE_ADDR;
   assign slot_wide = off >> SLOT_SHIFT;
   assign hit       = (bus.mem_addr >= BASE_ADDR) && (slot_wide < N_SLAVES);
   assign slot      = slot_wide[SW-1:0];
   assign req       = bus.mem_we | bus.mem_re;

   assign sel_ready = bus.s_ready[slot_q];
   assign sel_rdata = bus.s_rdata[32*slot_q +: 32];

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state plus latch/capture/error strobes for the datapath.
   always_comb begin
      state_nx  = state;
      latch_req = 1'b0;
      capture   = 1'b0;
      err_set   = 1'b0;
      err_kind  = 2'b00;
      err_at    = addr_q;
      unique case (state)
         IDLE: begin
            if (req) begin
               latch_req = 1'b1;
               if (hit) begin
                  state_nx = ACCESS;
               end else begin
                  state_nx = RESP;
                  err_set  = 1'b1;
                  err_kind = CAUSE_UNMAPPED;
                  err_at   = bus.mem_addr;
               end
            end
         end
         ACCESS: begin
            if (sel_ready) begin
               capture  = 1'b1;
               state_nx = RESP;
            end else if (cnt == CNT_LAST) begin
               state_nx = RESP;
               err_set  = 1'b1;
               err_kind = CAUSE_TIMEOUT;
            end
         end
         RESP: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Request latch, wait counter and response data; rdata starts at 0 so errors return 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         flag_q  <= '0;
         we_q    <= 1'b0;
         re_q    <= 1'b0;
         slot_q  <= '0;
         cnt     <= '0;
         rdata_q <= '0;
      end else begin
         if (latch_req) begin
            addr_q  <= bus.mem_addr;
            wdata_q <= bus.mem_wdata;
            flag_q  <= bus.mem_flag;
            we_q    <= bus.mem_we;
            re_q    <= bus.mem_re & ~bus.mem_we;
            slot_q  <= slot;
            cnt     <= '0;
            rdata_q <= '0;
         end else if (state == ACCESS && !sel_ready) begin
            cnt <= cnt + 1'b1;
         end
         if (capture) begin
            rdata_q <= we_q ? 32'h0 : sel_rdata;
         end
      end
   end

   // Sticky first-error record; a new error in the clear cycle is still recorded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q   <= 1'b0;
         cause_q <= 2'b00;
         eaddr_q <= '0;
      end else if (err_set && (!err_q || bus.err_clr)) begin
         err_q   <= 1'b1;
         cause_q <= err_kind;
         eaddr_q <= err_at;
      end else if (bus.err_clr) begin
         err_q   <= 1'b0;
         cause_q <= 2'b00;
         eaddr_q <= '0;
      end
   end

   // One-hot slot select, only while the access is in flight.
   always_comb begin
      sel_dec         = '0;
      sel_dec[slot_q] = (state == ACCESS);
   end

   assign bus.mem_ready = (state == RESP);
   assign bus.mem_rdata = (state == RESP) ? rdata_q : 32'h0;
   assign bus.s_sel     = sel_dec;
   assign bus.s_addr    = addr_q[SLOT_SHIFT-1:0];
   assign bus.s_wdata   = wdata_q;
   assign bus.s_flag    = flag_q;
   assign bus.s_we      = (state == ACCESS) & we_q;
   assign bus.s_re      = (state == ACCESS) & re_q;
   assign bus.bus_err   = err_q;
   assign bus.err_cause = cause_q;
   assign bus.err_addr  = eaddr_q;
endmodule

// File: tb/tb_periph_bus_bridge.sv
// Scoreboard bench for periph_bus_bridge: directed accesses push expected
// responses; a monitor pops and compares on every mem_ready.
module tb_periph_bus_bridge;
   localparam int N  = 4;
   localparam int SS = 12;
   localparam int T  = 255;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   periph_bus_bridge_if #(.N_SLAVES(N), .SLOT_SHIFT(SS)) bus ();

   periph_bus_bridge #(
      .N_SLAVES(N),
      .BASE_ADDR(32'h4000_0000),
      .SLOT_SHIFT(SS),
      .TIMEOUT_CYCLES(T),
      .TIMEOUT_W(8)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   typedef struct {
      logic [31:0] rdata;
      int          lat;
      logic        err;
      logic [1:0]  cause;
      logic [31:0] eaddr;
      int          issue;
      string       name;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int rdelay = -1;
   int acc_n = 0;
   logic [3:0] spur = 4'b0;

   logic        snap_v;
   logic [3:0]  snap_sel;
   logic [11:0] snap_addr;
   logic [31:0] snap_wdata;
   logic [2:0]  snap_flag;
   int          we_n;
   int          re_n;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Slot model: answers the selected slot after rdelay ACCESS cycles, plus spurious bits.
   initial begin
      bus.s_ready = '0;
      forever begin
         @(posedge clk);
         #2;
         if (bus.s_sel != '0) begin
            bus.s_ready = ((acc_n == rdelay) ? bus.s_sel : 4'b0) | spur;
            acc_n++;
         end else begin
            acc_n = 0;
            bus.s_ready = spur;
         end
      end
   end

   // Response monitor.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.mem_ready === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_mem_ready cycle=%0d actual=1 expected=0", cyc);
            end else begin
               e = sb.pop_front();
               check({e.name, "_rdata"}, bus.mem_rdata, e.rdata);
               check({e.name, "_latency"}, 32'(cyc - e.issue), 32'(e.lat));
               check({e.name, "_bus_err"}, 32'(bus.bus_err), 32'(e.err));
               check({e.name, "_err_cause"}, 32'(bus.err_cause), 32'(e.cause));
               check({e.name, "_err_addr"}, bus.err_addr, e.eaddr);
            end
         end
      end
   end

   // Slot-side snapshot: first ACCESS cycle values and strobe cycle counts.
   initial begin
      snap_v = 1'b0;
      we_n = 0;
      re_n = 0;
      forever begin
         @(negedge clk);
         if (bus.s_sel == '0 && !bus.mem_ready && (bus.mem_we || bus.mem_re)) begin
            snap_v = 1'b0;
            we_n = 0;
            re_n = 0;
         end
         if (bus.s_sel != '0) begin
            if (!snap_v) begin
               snap_v = 1'b1;
               snap_sel = bus.s_sel;
               snap_addr = bus.s_addr;
               snap_wdata = bus.s_wdata;
               snap_flag = bus.s_flag;
            end
            if (bus.s_we) we_n++;
            if (bus.s_re) re_n++;
            check("s_sel_onehot", 32'($countones(bus.s_sel)), 32'd1);
         end
      end
   end

   task automatic access(string nm, logic [31:0] a, logic [31:0] wd,
                         logic [2:0] fl, logic we, logic re, int dly,
                         logic [31:0] rd, int lat, logic ee,
                         logic [1:0] ec, logic [31:0] ea, logic clr);
      exp_t e;
      int n;
      rdelay = dly;
      e.rdata = rd;
      e.lat = lat;
      e.err = ee;
      e.cause = ec;
      e.eaddr = ea;
      e.issue = cyc;
      e.name = nm;
      sb.push_back(e);
      bus.mem_addr = a;
      bus.mem_wdata = wd;
      bus.mem_flag = fl;
      bus.mem_we = we;
      bus.mem_re = re;
      bus.err_clr = clr;
      @(posedge clk);
      #1;
      bus.err_clr = 1'b0;
      n = 0;
      while (bus.mem_ready !== 1'b1 && n < 600) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.mem_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_no_mem_ready actual=0 expected=1", nm);
      end
      @(posedge clk);
      #1;
      bus.mem_we = 1'b0;
      bus.mem_re = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(string nm);
      check({nm, "_mem_ready"}, 32'(bus.mem_ready), 32'd0);
      check({nm, "_mem_rdata"}, bus.mem_rdata, 32'd0);
      check({nm, "_s_sel"}, 32'(bus.s_sel), 32'd0);
      check({nm, "_s_we_re"}, 32'({bus.s_we, bus.s_re}), 32'd0);
      check({nm, "_s_addr"}, 32'(bus.s_addr), 32'd0);
      check({nm, "_s_wdata"}, bus.s_wdata, 32'd0);
      check({nm, "_s_flag"}, 32'(bus.s_flag), 32'd0);
      check({nm, "_bus_err"}, 32'(bus.bus_err), 32'd0);
      check({nm, "_err_cause"}, 32'(bus.err_cause), 32'd0);
      check({nm, "_err_addr"}, bus.err_addr, 32'd0);
   endtask

   task automatic pulse_clr();
      bus.err_clr = 1'b1;
      @(posedge clk);
      #1;
      bus.err_clr = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog_expired actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.mem_addr = '0;
      bus.mem_wdata = '0;
      bus.mem_flag = '0;
      bus.mem_we = 1'b0;
      bus.mem_re = 1'b0;
      bus.err_clr = 1'b0;
      bus.s_rdata = {32'hCAFEF00D, 32'h12345678, 32'h11111111, 32'h0BADF00D};
      repeat (3) @(posedge clk);
      #1;
      check_idle("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      access("rd_slot2", 32'h4000_2004, 32'h0, 3'b010, 1'b0, 1'b1, 0,
             32'h1234_5678, 2, 1'b0, 2'b00, 32'h0, 1'b0);
      check("rd_slot2_sel", 32'(snap_sel), 32'h4);
      check("rd_slot2_addr", 32'(snap_addr), 32'h004);
      check("rd_slot2_flag", 32'(snap_flag), 32'h2);
      check("rd_slot2_re_cycles", 32'(re_n), 32'd1);

      access("wr_slot0", 32'h4000_0010, 32'hA5A5_A5A5, 3'b010, 1'b1, 1'b0, 5,
             32'h0, 7, 1'b0, 2'b00, 32'h0, 1'b0);
      check("wr_slot0_sel", 32'(snap_sel), 32'h1);
      check("wr_slot0_addr", 32'(snap_addr), 32'h010);
      check("wr_slot0_wdata", snap_wdata, 32'hA5A5_A5A5);
      check("wr_slot0_we_cycles", 32'(we_n), 32'd6);
      check("wr_slot0_re_cycles", 32'(re_n), 32'd0);

      access("unmapped_hi", 32'h4000_4000, 32'h0, 3'b010, 1'b0, 1'b1, 0,
             32'h0, 1, 1'b1, 2'b01, 32'h4000_4000, 1'b0);
      check("unmapped_hi_no_sel", 32'(snap_v), 32'd0);

      access("last_byte", 32'h4000_3FFF, 32'h0, 3'b100, 1'b0, 1'b1, 1,
             32'hCAFE_F00D, 3, 1'b1, 2'b01, 32'h4000_4000, 1'b0);
      check("last_byte_sel", 32'(snap_sel), 32'h8);
      check("last_byte_addr", 32'(snap_addr), 32'hFFF);

      access("below_base", 32'h3FFF_FFFC, 32'h0, 3'b010, 1'b0, 1'b1, 0,
             32'h0, 1, 1'b1, 2'b01, 32'h4000_4000, 1'b0);

      pulse_clr();
      check("clr1_bus_err", 32'(bus.bus_err), 32'd0);
      check("clr1_err_cause", 32'(bus.err_cause), 32'd0);
      check("clr1_err_addr", bus.err_addr, 32'd0);

      access("timeout", 32'h4000_1008, 32'h0, 3'b010, 1'b0, 1'b1, -1,
             32'h0, T + 1, 1'b1, 2'b10, 32'h4000_1008, 1'b0);
      access("second_fault", 32'h5000_0000, 32'h0, 3'b010, 1'b0, 1'b1, 0,
             32'h0, 1, 1'b1, 2'b10, 32'h4000_1008, 1'b0);

      pulse_clr();
      check("clr2_bus_err", 32'(bus.bus_err), 32'd0);
      check("clr2_err_cause", 32'(bus.err_cause), 32'd0);
      check("clr2_err_addr", bus.err_addr, 32'd0);

      spur = 4'b1000;
      access("spurious", 32'h4000_1020, 32'h0, 3'b010, 1'b0, 1'b1, 2,
             32'h1111_1111, 4, 1'b0, 2'b00, 32'h0, 1'b0);
      check("spurious_sel", 32'(snap_sel), 32'h2);
      spur = 4'b0;

      access("we_and_re", 32'h4000_2008, 32'hDEAD_BEEF, 3'b010, 1'b1, 1'b1, 0,
             32'h0, 2, 1'b0, 2'b00, 32'h0, 1'b0);
      check("we_and_re_wdata", snap_wdata, 32'hDEAD_BEEF);
      check("we_and_re_we_cycles", 32'(we_n), 32'd1);
      check("we_and_re_re_cycles", 32'(re_n), 32'd0);

      access("err_first", 32'h6000_0000, 32'h0, 3'b010, 1'b0, 1'b1, 0,
             32'h0, 1, 1'b1, 2'b01, 32'h6000_0000, 1'b0);
      access("err_clr_race", 32'h6000_0100, 32'h0, 3'b010, 1'b0, 1'b1, 0,
             32'h0, 1, 1'b1, 2'b01, 32'h6000_0100, 1'b1);

      rdelay = -1;
      bus.mem_addr = 32'h4000_1000;
      bus.mem_we = 1'b0;
      bus.mem_re = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("mid_access_sel", 32'(bus.s_sel), 32'h2);
      rst_n = 1'b0;
      #1;
      check_idle("mid_reset");
      bus.mem_re = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;

      access("after_reset", 32'h4000_0000, 32'h0, 3'b010, 1'b0, 1'b1, 0,
             32'h0BAD_F00D, 2, 1'b0, 2'b00, 32'h0, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
